// File: rtl/execute_stage_if.sv
// ID/EX operands, writeback forwarding inputs and EX/MEM register outputs of the execute stage.
interface execute_stage_if;
    // ID/EX operands and control
    logic [15:0] Rd1_IDEX;
    logic [15:0] Rd2_IDEX;
    logic [2:0]  RsR_IDEX;
    logic [2:0]  RtR_IDEX;
    logic [15:0] Imm_IDEX;
    logic [15:0] PC2_IDEX;
    logic [3:0]  aluOp_IDEX;
    logic        aluSrc_IDEX;
    logic [1:0]  brType_IDEX;
    logic        jump_IDEX;
    logic        jumpReg_IDEX;
    logic        jumpAndLink_IDEX;
    logic        MemWrite_IDEX;
    logic        MemRead_IDEX;
    logic        MemtoReg_IDEX;
    logic        RegWrite_IDEX;
    logic        Dump_IDEX;
    logic        halt_IDEX;
    logic [2:0]  WrR_IDEX;
    logic        flush;
    // MEM/WB forwarding source
    logic        RegWrite_MEMWB;
    logic [2:0]  WrR_MEMWB;
    logic [15:0] WbData;
    // Results
    logic [15:0] ALUO_EXMEM;
    logic [15:0] Rd2_EXMEM;
    logic        takeBranch;
    logic        takeBranch_EXMEM;
    logic [15:0] brTarget;
    logic        MemWrite_EXMEM;
    logic        MemRead_EXMEM;
    logic        MemtoReg_EXMEM;
    logic        RegWrite_EXMEM;
    logic        Dump_EXMEM;
    logic        halt_EXMEM;
    logic        jumpAndLink_EXMEM;
    logic [2:0]  WrR_EXMEM;

    modport master (
        output Rd1_IDEX, Rd2_IDEX, RsR_IDEX, RtR_IDEX, Imm_IDEX, PC2_IDEX, aluOp_IDEX,
               aluSrc_IDEX, brType_IDEX, jump_IDEX, jumpReg_IDEX, jumpAndLink_IDEX,
               MemWrite_IDEX, MemRead_IDEX, MemtoReg_IDEX, RegWrite_IDEX, Dump_IDEX,
               halt_IDEX, WrR_IDEX, flush, RegWrite_MEMWB, WrR_MEMWB, WbData,
        input  ALUO_EXMEM, Rd2_EXMEM, takeBranch, takeBranch_EXMEM, brTarget,
               MemWrite_EXMEM, MemRead_EXMEM, MemtoReg_EXMEM, RegWrite_EXMEM,
               Dump_EXMEM, halt_EXMEM, jumpAndLink_EXMEM, WrR_EXMEM
    );

    modport slave (
        input  Rd1_IDEX, Rd2_IDEX, RsR_IDEX, RtR_IDEX, Imm_IDEX, PC2_IDEX, aluOp_IDEX,
               aluSrc_IDEX, brType_IDEX, jump_IDEX, jumpReg_IDEX, jumpAndLink_IDEX,
               MemWrite_IDEX, MemRead_IDEX, MemtoReg_IDEX, RegWrite_IDEX, Dump_IDEX,
               halt_IDEX, WrR_IDEX, flush, RegWrite_MEMWB, WrR_MEMWB, WbData,
        output ALUO_EXMEM, Rd2_EXMEM, takeBranch, takeBranch_EXMEM, brTarget,
               MemWrite_EXMEM, MemRead_EXMEM, MemtoReg_EXMEM, RegWrite_EXMEM,
               Dump_EXMEM, halt_EXMEM, jumpAndLink_EXMEM, WrR_EXMEM
    );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution and the EX/MEM pipeline register.
module execute_stage (
    input  logic          clk,
    input  logic          rst,
    execute_stage_if.slave bus
);
    localparam int unsigned DW = 16;
    localparam int unsigned RW = 3;

    logic [DW-1:0]   r_aluo;
    logic [DW-1:0]   r_rd2;
    logic [RW-1:0]   r_wr_r;
    logic            r_take_branch;
    logic            r_mem_write;
    logic            r_mem_read;
    logic            r_mem_to_reg;
    logic            r_reg_write;
    logic            r_dump;
    logic            r_halt;
    logic            r_jal;

    logic [DW-1:0]   w_a;
    logic [DW-1:0]   w_fwd_b;
    logic [DW-1:0]   w_b;
    logic [DW-1:0]   w_alu;
    logic [DW-1:0]   w_btr;
    logic [2*DW-1:0] w_rot_l;
    logic [2*DW-1:0] w_rot_r;
    logic [DW:0]     w_sum;
    logic [3:0]      w_shamt;
    logic            w_cond;
    logic            w_take;

    // Forwarding: EX/MEM non-load result first, then MEM/WB, else register file
    always_comb begin
        w_a = bus.Rd1_IDEX;
        if (r_reg_write && !r_mem_to_reg && (r_wr_r == bus.RsR_IDEX))
            w_a = r_aluo;
        else if (bus.RegWrite_MEMWB && (bus.WrR_MEMWB == bus.RsR_IDEX))
            w_a = bus.WbData;

        w_fwd_b = bus.Rd2_IDEX;
        if (r_reg_write && !r_mem_to_reg && (r_wr_r == bus.RtR_IDEX))
            w_fwd_b = r_aluo;
        else if (bus.RegWrite_MEMWB && (bus.WrR_MEMWB == bus.RtR_IDEX))
            w_fwd_b = bus.WbData;

        w_b = bus.aluSrc_IDEX ? bus.Imm_IDEX : w_fwd_b;
    end

    // ALU function select
    always_comb begin
        w_alu   = '0;
        w_shamt = w_b[3:0];
        w_rot_l = {w_a, w_a} << w_shamt;
        w_rot_r = {w_a, w_a} >> w_shamt;
        w_sum   = {1'b0, w_a} + {1'b0, w_b};
        w_btr   = '0;
        for (int i = 0; i < DW; i++)
            w_btr[i] = w_a[DW-1-i];
        case (bus.aluOp_IDEX)
            4'd0:  w_alu = w_sum[DW-1:0];
            4'd1:  w_alu = w_b - w_a;
            4'd2:  w_alu = w_a ^ w_b;
            4'd3:  w_alu = w_a & ~w_b;
            4'd4:  w_alu = w_rot_l[2*DW-1:DW];
            4'd5:  w_alu = w_a << w_shamt;
            4'd6:  w_alu = w_rot_r[DW-1:0];
            4'd7:  w_alu = w_a >> w_shamt;
            4'd8:  w_alu = w_b;
            4'd9:  w_alu = {w_a[7:0], w_b[7:0]};
            4'd10: w_alu = DW'(w_a == w_b);
            4'd11: w_alu = DW'($signed(w_a) < $signed(w_b));
            4'd12: w_alu = DW'($signed(w_a) <= $signed(w_b));
            4'd13: w_alu = DW'(w_sum[DW]);
            4'd14: w_alu = w_btr;
            default: w_alu = w_a;
        endcase
    end

    // Branch condition, redirect decision and target
    always_comb begin
        w_cond = 1'b0;
        case (bus.brType_IDEX)
            2'b01:   w_cond = (w_a == '0);
            2'b10:   w_cond = (w_a != '0);
            2'b11:   w_cond = w_a[DW-1];
            default: w_cond = 1'b0;
        endcase
        w_take = (bus.jump_IDEX || w_cond) && !bus.flush;
    end

    assign bus.takeBranch = w_take;
    assign bus.brTarget   = (bus.jumpReg_IDEX ? w_a : bus.PC2_IDEX) + bus.Imm_IDEX;

    // EX/MEM pipeline register; flush captures a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_aluo        <= '0;
            r_rd2         <= '0;
            r_wr_r        <= '0;
            r_take_branch <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_to_reg  <= 1'b0;
            r_reg_write   <= 1'b0;
            r_dump        <= 1'b0;
            r_halt        <= 1'b0;
            r_jal         <= 1'b0;
        end else begin
            r_aluo        <= bus.jumpAndLink_IDEX ? bus.PC2_IDEX : w_alu;
            r_rd2         <= w_fwd_b;
            r_wr_r        <= bus.WrR_IDEX;
            r_take_branch <= w_take;
            r_mem_to_reg  <= bus.MemtoReg_IDEX;
            r_mem_write   <= bus.MemWrite_IDEX    && !bus.flush;
            r_mem_read    <= bus.MemRead_IDEX     && !bus.flush;
            r_reg_write   <= bus.RegWrite_IDEX    && !bus.flush;
            r_dump        <= bus.Dump_IDEX        && !bus.flush;
            r_halt        <= bus.halt_IDEX        && !bus.flush;
            r_jal         <= bus.jumpAndLink_IDEX && !bus.flush;
        end
    end

    assign bus.ALUO_EXMEM        = r_aluo;
    assign bus.Rd2_EXMEM         = r_rd2;
    assign bus.WrR_EXMEM         = r_wr_r;
    assign bus.takeBranch_EXMEM  = r_take_branch;
    assign bus.MemWrite_EXMEM    = r_mem_write;
    assign bus.MemRead_EXMEM     = r_mem_read;
    assign bus.MemtoReg_EXMEM    = r_mem_to_reg;
    assign bus.RegWrite_EXMEM    = r_reg_write;
    assign bus.Dump_EXMEM        = r_dump;
    assign bus.halt_EXMEM        = r_halt;
    assign bus.jumpAndLink_EXMEM = r_jal;
endmodule

// File: tb/tb_execute_stage.sv
// Directed testbench for execute_stage.
module tb_execute_stage;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    execute_stage_if bus ();

    execute_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.Rd1_IDEX = '0;  bus.Rd2_IDEX = '0;  bus.RsR_IDEX = '0;  bus.RtR_IDEX = '0;
        bus.Imm_IDEX = '0;  bus.PC2_IDEX = '0;  bus.aluOp_IDEX = '0; bus.aluSrc_IDEX = 1'b0;
        bus.brType_IDEX = '0; bus.jump_IDEX = 1'b0; bus.jumpReg_IDEX = 1'b0;
        bus.jumpAndLink_IDEX = 1'b0; bus.MemWrite_IDEX = 1'b0; bus.MemRead_IDEX = 1'b0;
        bus.MemtoReg_IDEX = 1'b0; bus.RegWrite_IDEX = 1'b0; bus.Dump_IDEX = 1'b0;
        bus.halt_IDEX = 1'b0; bus.WrR_IDEX = '0; bus.flush = 1'b0;
        bus.RegWrite_MEMWB = 1'b0; bus.WrR_MEMWB = '0; bus.WbData = '0;
    endtask

    // One ALU op with A from Rd1 (no forwarding) and B from the immediate
    task automatic alu_vec(input string tag, input logic [3:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] exp);
        @(negedge clk);
        clear_inputs();
        bus.aluOp_IDEX = op; bus.Rd1_IDEX = a; bus.RsR_IDEX = 3'd1;
        bus.aluSrc_IDEX = 1'b1; bus.Imm_IDEX = b;
        @(posedge clk); #1;
        check_eq(tag, bus.ALUO_EXMEM, exp);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_aluo", bus.ALUO_EXMEM, 16'h0000);
        check_eq("rst_regwrite", 16'(bus.RegWrite_EXMEM), 16'h0000);
        check_eq("rst_tb", 16'(bus.takeBranch_EXMEM), 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        // ADD R1 = 3 + 4, then SUB with Rs=R1 back to back
        @(negedge clk);
        clear_inputs();
        bus.RsR_IDEX = 3'd2; bus.Rd1_IDEX = 16'd3; bus.RtR_IDEX = 3'd3; bus.Rd2_IDEX = 16'd4;
        bus.WrR_IDEX = 3'd1; bus.RegWrite_IDEX = 1'b1;
        @(posedge clk); #1;
        check_eq("add_aluo", bus.ALUO_EXMEM, 16'd7);
        check_eq("add_wrr", 16'(bus.WrR_EXMEM), 16'd1);
        @(negedge clk);
        clear_inputs();
        bus.aluOp_IDEX = 4'd1; bus.RsR_IDEX = 3'd1; bus.Rd1_IDEX = 16'd0;
        bus.RtR_IDEX = 3'd4; bus.Rd2_IDEX = 16'd10; bus.WrR_IDEX = 3'd2; bus.RegWrite_IDEX = 1'b1;
        @(posedge clk); #1;
        check_eq("sub_fwd_aluo", bus.ALUO_EXMEM, 16'd3);
        check_eq("sub_rd2", bus.Rd2_EXMEM, 16'd10);

        // Double hazard: R5=5 in EX/MEM, R5=9 in MEM/WB
        @(negedge clk);
        clear_inputs();
        bus.aluOp_IDEX = 4'd8; bus.aluSrc_IDEX = 1'b1; bus.Imm_IDEX = 16'd5;
        bus.WrR_IDEX = 3'd5; bus.RegWrite_IDEX = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        bus.aluOp_IDEX = 4'd15; bus.RsR_IDEX = 3'd5; bus.RtR_IDEX = 3'd5;
        bus.RegWrite_MEMWB = 1'b1; bus.WrR_MEMWB = 3'd5; bus.WbData = 16'd9;
        bus.jumpReg_IDEX = 1'b1;
        #1;
        check_eq("dbl_a_comb", bus.brTarget, 16'd5);
        @(posedge clk); #1;
        check_eq("dbl_aluo", bus.ALUO_EXMEM, 16'd5);
        check_eq("dbl_rd2", bus.Rd2_EXMEM, 16'd5);
        @(negedge clk); #1;
        check_eq("memwb_a_comb", bus.brTarget, 16'd9);
        @(posedge clk);

        // EX/MEM load is not a forwarding source
        @(negedge clk);
        clear_inputs();
        bus.aluOp_IDEX = 4'd8; bus.aluSrc_IDEX = 1'b1; bus.Imm_IDEX = 16'h1111;
        bus.WrR_IDEX = 3'd3; bus.RegWrite_IDEX = 1'b1; bus.MemtoReg_IDEX = 1'b1; bus.MemRead_IDEX = 1'b1;
        @(posedge clk); #1;
        check_eq("ld_memread", 16'(bus.MemRead_EXMEM), 16'd1);
        @(negedge clk);
        clear_inputs();
        bus.RsR_IDEX = 3'd3; bus.Rd1_IDEX = 16'h2222; bus.jumpReg_IDEX = 1'b1;
        bus.RegWrite_MEMWB = 1'b1; bus.WrR_MEMWB = 3'd3; bus.WbData = 16'h3333;
        #1;
        check_eq("ld_to_memwb", bus.brTarget, 16'h3333);
        bus.RegWrite_MEMWB = 1'b0;
        #1;
        check_eq("ld_to_rf", bus.brTarget, 16'h2222);
        @(posedge clk);

        // BLTZ taken / not taken, A forwarded from MEM/WB
        @(negedge clk);
        clear_inputs();
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        bus.brType_IDEX = 2'b11; bus.RsR_IDEX = 3'd2; bus.PC2_IDEX = 16'h0010; bus.Imm_IDEX = 16'hFFFC;
        bus.RegWrite_MEMWB = 1'b1; bus.WrR_MEMWB = 3'd2; bus.WbData = 16'h8000;
        #1;
        check_eq("bltz_take", 16'(bus.takeBranch), 16'd1);
        check_eq("bltz_target", bus.brTarget, 16'h000C);
        @(posedge clk); #1;
        check_eq("bltz_take_reg", 16'(bus.takeBranch_EXMEM), 16'd1);
        @(negedge clk);
        bus.WbData = 16'h0001;
        #1;
        check_eq("bltz_not", 16'(bus.takeBranch), 16'd0);
        @(posedge clk); #1;
        check_eq("bltz_not_reg", 16'(bus.takeBranch_EXMEM), 16'd0);
        @(negedge clk);
        clear_inputs();
        bus.brType_IDEX = 2'b01; bus.RsR_IDEX = 3'd6;
        #1;
        check_eq("beqz_take", 16'(bus.takeBranch), 16'd1);
        bus.brType_IDEX = 2'b10;
        #1;
        check_eq("bnez_not", 16'(bus.takeBranch), 16'd0);
        @(posedge clk);

        // JAL
        @(negedge clk);
        clear_inputs();
        bus.jump_IDEX = 1'b1; bus.jumpAndLink_IDEX = 1'b1; bus.RegWrite_IDEX = 1'b1;
        bus.WrR_IDEX = 3'd7; bus.PC2_IDEX = 16'h0040; bus.Imm_IDEX = 16'h0010;
        bus.RsR_IDEX = 3'd1; bus.Rd1_IDEX = 16'd5;
        #1;
        check_eq("jal_take", 16'(bus.takeBranch), 16'd1);
        check_eq("jal_target", bus.brTarget, 16'h0050);
        @(posedge clk); #1;
        check_eq("jal_aluo", bus.ALUO_EXMEM, 16'h0040);
        check_eq("jal_regwrite", 16'(bus.RegWrite_EXMEM), 16'd1);
        check_eq("jal_link", 16'(bus.jumpAndLink_EXMEM), 16'd1);
        check_eq("jal_wrr", 16'(bus.WrR_EXMEM), 16'd7);

        // Flush beats a taken jump; store/halt squashed
        @(negedge clk);
        clear_inputs();
        bus.MemWrite_IDEX = 1'b1; bus.halt_IDEX = 1'b1; bus.Dump_IDEX = 1'b1;
        bus.RegWrite_IDEX = 1'b1; bus.jump_IDEX = 1'b1; bus.flush = 1'b1;
        #1;
        check_eq("flush_take", 16'(bus.takeBranch), 16'd0);
        @(posedge clk); #1;
        check_eq("flush_memwrite", 16'(bus.MemWrite_EXMEM), 16'd0);
        check_eq("flush_halt", 16'(bus.halt_EXMEM), 16'd0);
        check_eq("flush_dump", 16'(bus.Dump_EXMEM), 16'd0);
        check_eq("flush_regwrite", 16'(bus.RegWrite_EXMEM), 16'd0);
        check_eq("flush_take_reg", 16'(bus.takeBranch_EXMEM), 16'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        @(posedge clk); #1;
        check_eq("noflush_memwrite", 16'(bus.MemWrite_EXMEM), 16'd1);
        check_eq("noflush_halt", 16'(bus.halt_EXMEM), 16'd1);

        // ALU sweep with corner operands
        alu_vec("add",    4'd0,  16'h8000, 16'hFFFF, 16'h7FFF);
        alu_vec("sub_a",  4'd1,  16'h8000, 16'hFFFF, 16'h7FFF);
        alu_vec("sub_b",  4'd1,  16'hFFFF, 16'h8000, 16'h8001);
        alu_vec("xor",    4'd2,  16'h8000, 16'hFFFF, 16'h7FFF);
        alu_vec("andn",   4'd3,  16'hFFFF, 16'h8000, 16'h7FFF);
        alu_vec("rol1",   4'd4,  16'h8000, 16'h0001, 16'h0001);
        alu_vec("rol0",   4'd4,  16'h8000, 16'h0000, 16'h8000);
        alu_vec("rol15",  4'd4,  16'h8001, 16'h000F, 16'hC000);
        alu_vec("sll15",  4'd5,  16'hFFFF, 16'h000F, 16'h8000);
        alu_vec("sll0",   4'd5,  16'hFFFF, 16'h0010, 16'hFFFF);
        alu_vec("ror15",  4'd6,  16'h0001, 16'h000F, 16'h0002);
        alu_vec("ror1",   4'd6,  16'h8001, 16'h0001, 16'hC000);
        alu_vec("srl15",  4'd7,  16'h8000, 16'h000F, 16'h0001);
        alu_vec("srl0",   4'd7,  16'hFFFF, 16'h0000, 16'hFFFF);
        alu_vec("passb",  4'd8,  16'h8000, 16'hFFFF, 16'hFFFF);
        alu_vec("slbi",   4'd9,  16'h00AB, 16'hFFCD, 16'hABCD);
        alu_vec("seq1",   4'd10, 16'hFFFF, 16'hFFFF, 16'h0001);
        alu_vec("seq0",   4'd10, 16'h8000, 16'hFFFF, 16'h0000);
        alu_vec("slt1",   4'd11, 16'h8000, 16'hFFFF, 16'h0001);
        alu_vec("slt0",   4'd11, 16'hFFFF, 16'h8000, 16'h0000);
        alu_vec("slteq",  4'd11, 16'hFFFF, 16'hFFFF, 16'h0000);
        alu_vec("sle_eq", 4'd12, 16'hFFFF, 16'hFFFF, 16'h0001);
        alu_vec("sle0",   4'd12, 16'hFFFF, 16'h8000, 16'h0000);
        alu_vec("sco1",   4'd13, 16'h8000, 16'h8000, 16'h0001);
        alu_vec("sco0",   4'd13, 16'h8000, 16'h7FFF, 16'h0000);
        alu_vec("sco_ff", 4'd13, 16'hFFFF, 16'h0001, 16'h0001);
        alu_vec("btr_a",  4'd14, 16'h8000, 16'h0000, 16'h0001);
        alu_vec("btr_b",  4'd14, 16'h00FF, 16'h0000, 16'hFF00);
        alu_vec("passa",  4'd15, 16'h8000, 16'hFFFF, 16'h8000);

        // Asynchronous reset between clock edges
        @(negedge clk);
        clear_inputs();
        bus.aluOp_IDEX = 4'd8; bus.aluSrc_IDEX = 1'b1; bus.Imm_IDEX = 16'hABCD;
        bus.RegWrite_IDEX = 1'b1; bus.WrR_IDEX = 3'd4; bus.Rd2_IDEX = 16'h1234; bus.jump_IDEX = 1'b1;
        @(posedge clk); #1;
        check_eq("pre_rst_aluo", bus.ALUO_EXMEM, 16'hABCD);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_aluo", bus.ALUO_EXMEM, 16'h0000);
        check_eq("arst_rd2", bus.Rd2_EXMEM, 16'h0000);
        check_eq("arst_wrr", 16'(bus.WrR_EXMEM), 16'h0000);
        check_eq("arst_tb", 16'(bus.takeBranch_EXMEM), 16'h0000);
        check_eq("arst_regwrite", 16'(bus.RegWrite_EXMEM), 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the 5-stage 16-bit pipeline. Takes ID/EX operands and control and resolves operand forwarding from EX/MEM and MEM/WB. Computes the ALU result and the branch/jump decision and target, then registers everything into the EX/MEM pipeline register consumed by the memory stage. It also produces the combinational `takeBranch` used for same-cycle redirect and downstream halt suppression.

## Interface
Parameters: none (datapath fixed at 16 bits, register index 3 bits).

- `clk` in 1: pipeline clock; all state rising-edge.
- `rst` in 1: asynchronous, active-high; clears EX/MEM register.
- `Rd1_IDEX`, `Rd2_IDEX` in 16: register-file read data for Rs, Rt.
- `RsR_IDEX`, `RtR_IDEX` in 3: source register indices, for forwarding.
- `Imm_IDEX` in 16: sign/zero-extended immediate.
- `PC2_IDEX` in 16: PC+2 of the instruction.
- `aluOp_IDEX` in 4: ALU function (see Operation).
- `aluSrc_IDEX` in 1: B operand = 1 ? `Imm_IDEX` : forwarded Rt.
- `brType_IDEX` in 2: 00 none, 01 BEQZ, 10 BNEZ, 11 BLTZ.
- `jump_IDEX` in 1: unconditional jump.
- `jumpReg_IDEX` in 1: jump target uses register.
- `jumpAndLink_IDEX` in 1: link.
- Control inputs, each 1 bit: `MemWrite_IDEX`, `MemRead_IDEX`, `MemtoReg_IDEX`, `RegWrite_IDEX`, `Dump_IDEX`, `halt_IDEX`.
- `WrR_IDEX` in 3: destination register.
- `flush` in 1: squash the instruction currently in EX.
- `RegWrite_MEMWB` in 1, `WrR_MEMWB` in 3, `WbData` in 16: writeback-stage result for forwarding.
- `ALUO_EXMEM` out 16, `Rd2_EXMEM` out 16 (forwarded Rt).
- `takeBranch` out 1 (combinational), `takeBranch_EXMEM` out 1 (registered).
- `brTarget` out 16 (combinational).
- Registered control outputs, each 1 bit: `MemWrite_EXMEM`, `MemRead_EXMEM`, `MemtoReg_EXMEM`, `RegWrite_EXMEM`, `Dump_EXMEM`, `halt_EXMEM`, `jumpAndLink_EXMEM`.
- `WrR_EXMEM` out 3.

## Operation
**Forwarding**, applied per operand independently. The rule is shown for A (Rs); B (Rt) is identical.
- Priority 1, EX/MEM: if `RegWrite_EXMEM & ~MemtoReg_EXMEM & WrR_EXMEM==RsR_IDEX`, use `ALUO_EXMEM`.
- Priority 2, MEM/WB: else if `RegWrite_MEMWB & WrR_MEMWB==RsR_IDEX`, use `WbData`.
- Otherwise: use `Rd1_IDEX`.
- R0 is a real register; it is forwarded like any other.
- Load-use stalls belong to the hazard unit; this block never stalls.

**ALU**: A = forwarded Rs; B = `aluSrc` mux. Results are 16-bit, overflow discarded.
- 0 ADD A+B; 1 SUB B−A; 2 XOR; 3 ANDN A&~B.
- 4 ROL, 5 SLL, 6 ROR, 7 SRL: shift/rotate A by B[3:0].
- 8 PASSB; 9 SLBI (A<<8)|B[7:0].
- 10 SEQ, 11 SLT (signed), 12 SLE (signed): result 16'h0001 or 16'h0000.
- 13 SCO: carry-out of the 17-bit A+B.
- 14 BTR: A bit-reversed.
- 15 PASSA.

**Branch/jump**:
- Conditions test forwarded A: BEQZ A==0; BNEZ A!=0; BLTZ A[15].
- `takeBranch = jump_IDEX | (brType!=0 & cond)`, forced 0 when `flush`.
- `brTarget = jumpReg ? A+Imm : PC2+Imm`.
- If `jumpAndLink_IDEX`, the registered ALUO is `PC2_IDEX` instead of the ALU result.

**EX/MEM register**: captures ALUO, forwarded B, WrR, all control, and `takeBranch` every cycle (no enable).
- On `flush`, capture MemWrite, MemRead, RegWrite, Dump, halt, jumpAndLink and takeBranch as 0; datapath values are don't-care.

## Timing
- Forwarding, ALU, `takeBranch` and `brTarget` are combinational within the EX cycle.
- The EX/MEM register updates on the next rising edge: latency 1 cycle.
- Back-to-back dependent ALU ops forward with zero bubbles.
- `rst` asserted at any time: every EX/MEM output goes to 0 immediately, without waiting for a clock edge.
  - This includes `ALUO_EXMEM`, `Rd2_EXMEM`, `WrR_EXMEM` and `takeBranch_EXMEM`.
  - An instruction in flight is lost.
- `flush` and `takeBranch` conditions in the same cycle: flush wins; no redirect, bubble registered.
- EX/MEM and MEM/WB both match the same source index: EX/MEM data is used.
- An EX/MEM load (`MemtoReg`) matching a source: not forwarded from EX/MEM; falls through to the MEM/WB check or the register file.

## Test plan
- **Reset**: `rst` pulse mid-run, between clock edges → all EX/MEM outputs read 0 before the next edge.
- **EX/MEM forwarding**: ADD R1=3+4, then SUB with Rs=R1 → second instruction's A=7 forwarded, no bubble.
- **Double hazard**: same destination in both EX/MEM (value 5) and MEM/WB (value 9) → EX/MEM value 5 wins.
- **Branch resolution**:
  - BLTZ with forwarded A=16'h8000, PC2=16'h0010, Imm=16'hFFFC → `takeBranch`=1, `brTarget`=16'h000C, `takeBranch_EXMEM`=1 next cycle.
  - Same instruction with A=1 → not taken.
- **JAL**: PC2=16'h0040 → `ALUO_EXMEM`=16'h0040, `RegWrite_EXMEM`=1, `jumpAndLink_EXMEM`=1.
- **Flush**: store with halt=1 while `flush`=1 → `MemWrite_EXMEM`=0, `halt_EXMEM`=0, `takeBranch`=0.
- **ALU sweep**: all 16 aluOps with corner operands 16'h8000 and 16'hFFFF, including shift amounts 0 and 15 → SLT/SLE signed results correct, SCO carry correct.
